// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a (package only).
// Backpressure: n/a. S_CHK exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int LEN_BYTES      = 2;  // header bytes carrying the word count
    localparam int BYTES_PER_WORD = 4;
    localparam int CHK_W          = 8;  // checksum accumulator width

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // State entered once the header/data portion of the stream is complete.
    localparam state_t S_POST_DATA = S_CHK;
`else
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam state_t S_POST_DATA = S_DONE;
`endif

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_done flags the completing byte.
// Latency: combinational word/word_done on the 4th byte; partial bytes held in registers.
// Backpressure: none; shifts whenever shift_en is high (caller gates with its handshake).
// Ports: clk, rst (sync, active-high), shift_en, byte_in[7:0] -> word[31:0], word_done.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam int SR_W  = 8 * (BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx;
    logic [SR_W-1:0]  sr;  // the first three bytes of the current word, oldest lowest

    // Newest byte lands on top so the first byte received ends up as the LSB.
    assign word      = {byte_in, sr};
    assign word_done = shift_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            idx <= idx + 1'b1;  // wraps naturally after the 4th byte
            sr  <= {byte_in, sr[SR_W-1:8]};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian words written to imem from address 0.
// Latency: write one cycle after a word's 4th byte; done/core_rst release one cycle after the final write.
// Backpressure: rx_ready high in all loading states, never drops mid-word; low in S_DONE, S_ERR and during rst.
// Ports: clk, rst (sync, active-high), rx_data/rx_valid/rx_ready stream in,
//        imem_we/imem_addr/imem_wdata write port, core_rst, done, error (sticky).
// Optional: define LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    state_t           state;
    logic [7:0]       len_lo;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] n_next;
    logic             accept;
    logic [31:0]      word;
    logic             word_done;

    assign rx_ready = !rst && (state == S_LEN0 || state == S_LEN1 || state == S_DATA
`ifdef LOADER_CHECKSUM_EN
                               || state == S_CHK
`endif
                              );
    assign accept   = rx_valid && rx_ready;
    assign n_next   = CNT_W'({rx_data, len_lo});

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (accept && state == S_DATA),
        .byte_in   (rx_data),
        .word      (word),
        .word_done (word_done)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] acc;
    logic             chk_ok;

    // A correct CHK byte brings the running sum of the whole stream to zero.
    assign chk_ok = (CHK_W'(acc + rx_data) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= (state == S_LEN0) ? rx_data : CHK_W'(acc + rx_data);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN0;
            len_lo     <= '0;
            len        <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN0: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        len <= n_next;
                        if (n_next > CNT_W'(DEPTH_WORDS))
                            state <= S_ERR;
                        else if (n_next == '0)
                            state <= S_POST_DATA;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_done) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= 32'({word_idx, 2'b00});
                        imem_wdata <= word;
                        word_idx   <= word_idx + 1'b1;
                        if (word_idx == len - CNT_W'(1))
                            state <= S_POST_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                // Outputs are set here directly so they move the cycle after CHK.
                S_CHK: begin
                    if (accept) begin
                        if (chk_ok) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    done     <= 1'b1;
                    core_rst <= 1'b0;
                end
                S_ERR: begin
                    error    <= 1'b1;
                    core_rst <= 1'b1;
                end
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    logic [63:0] exp_q[$];   // {addr, data} of each expected write
    logic [31:0] img[0:7];
    logic [7:0]  sum;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write cycle pops one expected entry.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [63:0] e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;      // byte presented during reset must be dropped
        rx_data  = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_in_reset got=%b expected=0", rx_ready);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h rx_ready=%b expected=1", b, rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        sum = sum + b;
    endtask

    task automatic load_image(input int n, input logic [15:0] len_field, input int max_gap,
                              input logic [7:0] chk_delta);
        logic [7:0] c;
        sum = 8'h00;
        send_byte(len_field[7:0], 0);
        send_byte(len_field[15:8], $urandom_range(0, max_gap));
        for (int w = 0; w < n; w++) begin
            logic [31:0] d;
            d = img[w];
            exp_q.push_back({32'(w * 4), d});
            for (int k = 0; k < 4; k++)
                send_byte(d[8*k +: 8], $urandom_range(0, max_gap));
        end
        if (CHK) begin
            c = 8'h00 - sum + chk_delta;
            send_byte(c, $urandom_range(0, max_gap));
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, core_rst, done, error} !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values we=%b addr=%h data=%h core_rst=%b done=%b error=%b expected 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, core_rst, done, error);
        end
        check_bit("reset_rx_ready", rx_ready, 1'b1);
    endtask

    task automatic test_basic();
        do_reset();
        wr_count = 0;
        img[0] = 32'h00500513;
        img[1] = 32'h00A00593;
        load_image(2, 16'd2, 0, 8'h00);
        @(negedge clk);
        if (!CHK) begin
            check_bit("basic_done_t1", done, 1'b0);
            @(negedge clk);
        end
        check_bit("basic_done", done, 1'b1);
        check_bit("basic_core_rst", core_rst, 1'b0);
        check_bit("basic_rx_ready_after_done", rx_ready, 1'b0);
        @(posedge clk);
        checks++;
        if (wr_count != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_writes got=%0d pending=%0d expected=2 pending=0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_checksum_bad();
        do_reset();
        img[0] = 32'h00500513;
        img[1] = 32'h00A00593;
        load_image(2, 16'd2, 0, 8'h01);
        @(negedge clk);
        check_bit("chk_bad_error", error, 1'b1);
        check_bit("chk_bad_done", done, 1'b0);
        check_bit("chk_bad_core_rst", core_rst, 1'b1);
        check_bit("chk_bad_rx_ready", rx_ready, 1'b0);
    endtask

    task automatic test_oversize();
        do_reset();
        wr_count = 0;
        sum = 8'h00;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check_bit("oversize_error_t1", error, 1'b0);
        check_bit("oversize_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        check_bit("oversize_error", error, 1'b1);
        check_bit("oversize_core_rst", core_rst, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h13;
        repeat (8) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_bit("oversize_error_sticky", error, 1'b1);
        checks++;
        if (wr_count != 0) begin
            errors++;
            $display("FAIL oversize_writes got=%0d expected=0", wr_count);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        wr_count = 0;
        load_image(0, 16'd0, 0, 8'h00);
        @(negedge clk);
        if (!CHK) begin
            check_bit("zero_done_t1", done, 1'b0);
            @(negedge clk);
        end
        check_bit("zero_done", done, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_bit("zero_rx_ready", rx_ready, 1'b0);
        rx_valid = 1'b0;
        check_bit("zero_done_sticky", done, 1'b1);
        checks++;
        if (wr_count != 0) begin
            errors++;
            $display("FAIL zero_writes got=%0d expected=0", wr_count);
        end
    endtask

    task automatic test_random_valid();
        do_reset();
        wr_count = 0;
        img[0] = 32'h11223344;
        img[1] = 32'hCAFEF00D;
        img[2] = 32'h00000073;
        load_image(3, 16'd3, 3, 8'h00);
        repeat (3) @(negedge clk);
        check_bit("random_done", done, 1'b1);
        checks++;
        if (wr_count != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_writes got=%0d pending=%0d expected=3 pending=0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d;
        do_reset();
        wr_count = 0;
        sum = 8'h00;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        d = 32'h00500513;
        exp_q.push_back({32'h0, d});
        for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8], 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        do_reset();
        img[0] = 32'hDEADBEEF;
        load_image(1, 16'd1, 0, 8'h00);
        repeat (3) @(negedge clk);
        check_bit("midrst_done", done, 1'b1);
        checks++;
        if (wr_count != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_writes got=%0d pending=%0d expected=2 pending=0", wr_count, exp_q.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        sum      = 8'h00;
        test_reset();
        test_basic();
        if (CHK) test_checksum_bad();
        test_oversize();
        test_zero_len();
        test_random_valid();
        test_reset_mid_load();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
